// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable synchronised lock, then
// releases the PLL-domain system reset and tracks lock losses and lock-wait timeouts.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             clr_stats,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sync1, locked_s;
    logic          lost_ev, retry_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked;
            locked_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Every transition restarts the shared counter from zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        lost_ev   = 1'b0;
        retry_ev  = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                    retry_ev  = 1'b1;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    lost_ev   = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A clear that coincides with an event leaves exactly that one event recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt  <= '0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
        end else if (clr_stats) begin
            lost_cnt  <= lost_ev ? CNT_W'(1) : '0;
            retry_cnt <= retry_ev ? CNT_W'(1) : '0;
            lock_lost <= lost_ev;
        end else begin
            if (lost_ev && (lost_cnt != '1)) begin
                lost_cnt <= lost_cnt + CNT_W'(1);
            end
            if (retry_ev && (retry_cnt != '1)) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
            if (lost_ev) begin
                lock_lost <= 1'b1;
            end
        end
    end

    assign pll_rst   = (state == RESET_PLL);
    assign sys_rst_n = (state == RUN);
    assign ready     = (state == RUN);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed vector table, multi-cycle corner sequences
// and randomised lock activity, all compared against a phase/timeline reference model.
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_SET  = 8;
    localparam int P_W    = 4;
    localparam int CNTMAX = (1 << P_W) - 1;

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           locked;
    logic           clr_stats;
    logic           pll_rst;
    logic           sys_rst_n;
    logic           ready;
    logic           lock_lost;
    logic [P_W-1:0] lost_cnt;
    logic [P_W-1:0] retry_cnt;

    int checks = 0;
    int passes = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .SETTLE_CYCLES (P_SET),
        .CNT_W         (P_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .locked   (locked),
        .clr_stats(clr_stats),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready    (ready),
        .lock_lost(lock_lost),
        .lost_cnt (lost_cnt),
        .retry_cnt(retry_cnt)
    );

    always #10 clk = ~clk;

    // Reference model: the phase plus the edge index at which it began, and a delay line
    // of raw lock samples standing in for the synchroniser latency.
    int   m_phase;
    int   m_start;
    int   m_edge = 0;
    int   m_lost;
    int   m_retry;
    int   m_ll;
    logic m_dly[$];

    typedef struct {
        logic lk;
        logic clr;
        int   cycles;
        logic exp_pll_rst;
        logic exp_ready;
        int   exp_lost;
        logic exp_ll;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_RESET;
        m_start = m_edge;
        m_lost  = 0;
        m_retry = 0;
        m_ll    = 0;
        m_dly   = {1'b0, 1'b0};
    endtask

    task automatic model_edge(input logic lk, input logic clr);
        logic ls;
        int   spent;
        int   nxt;
        int   lost_ev;
        int   retry_ev;
        ls       = m_dly.pop_front();
        m_dly.push_back(lk);
        spent    = m_edge - m_start;
        nxt      = m_phase;
        lost_ev  = 0;
        retry_ev = 0;
        if (m_phase == PH_RESET) begin
            if (spent + 1 == P_RST) nxt = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (ls) nxt = PH_SETTLE;
            else if (spent + 1 == P_TO) begin
                nxt      = PH_RESET;
                retry_ev = 1;
            end
        end else if (m_phase == PH_SETTLE) begin
            if (!ls) nxt = PH_WAIT;
            else if (spent + 1 == P_SET) nxt = PH_RUN;
        end else begin
            if (!ls) begin
                nxt     = PH_WAIT;
                lost_ev = 1;
            end
        end
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_start = m_edge + 1;
        end
        if (clr) begin
            m_lost  = lost_ev;
            m_retry = retry_ev;
            m_ll    = lost_ev;
        end else begin
            m_lost  = (m_lost + lost_ev > CNTMAX) ? CNTMAX : m_lost + lost_ev;
            m_retry = (m_retry + retry_ev > CNTMAX) ? CNTMAX : m_retry + retry_ev;
            m_ll    = m_ll | lost_ev;
        end
        m_edge++;
    endtask

    task automatic check_model();
        logic [15:0] act;
        logic [15:0] exp;
        act = {pll_rst, sys_rst_n, ready, lock_lost, lost_cnt, retry_cnt, 4'h0};
        exp = {(m_phase == PH_RESET), (m_phase == PH_RUN), (m_phase == PH_RUN), (m_ll != 0),
               4'(m_lost), 4'(m_retry), 4'h0};
        checkOutput("model", int'(act), int'(exp));
    endtask

    // One clock: the model advances at the edge, the DUT is compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(locked, clr_stats);
        @(negedge clk);
        check_model();
    endtask

    task automatic applyStimulus(input logic lk, input logic clr, input int n);
        locked    = lk;
        clr_stats = clr;
        repeat (n) tick();
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int hi;
        int lo;
        int hold;
        logic lk;

        vecs[0] = '{1'b0, 1'b0, 3,  1'b1, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3,  1'b0, 1'b1, 0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 2,  1'b0, 1'b1, 0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 1, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1, 1'b1};

        rst_n     = 1'b0;
        locked    = 1'b0;
        clr_stats = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checkOutput("reset_pll_rst", int'(pll_rst), 1);
        checkOutput("reset_sys_rst_n", int'(sys_rst_n), 0);
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_counters", int'({lock_lost, lost_cnt, retry_cnt}), 0);
        model_reset();
        rst_n = 1'b1;

        // Power-up release, then a lock loss in RUN and relock.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].lk, vecs[i].clr, vecs[i].cycles);
            checkOutput($sformatf("vec%0d_pll_rst", i), int'(pll_rst), int'(vecs[i].exp_pll_rst));
            checkOutput($sformatf("vec%0d_sys_rst_n", i), int'(sys_rst_n), int'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_lost_cnt", i), int'(lost_cnt), vecs[i].exp_lost);
            checkOutput($sformatf("vec%0d_lock_lost", i), int'(lock_lost), int'(vecs[i].exp_ll));
        end

        // Glitch at settle count 5: lock drops for one cycle, release 10 edges after re-rise.
        applyStimulus(1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 6);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("glitch_not_yet_released", int'(sys_rst_n), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("glitch_released", int'(sys_rst_n), 1);
        checkOutput("glitch_lost_cnt", int'(lost_cnt), 2);

        // Bring lost_cnt to 5, then clear in the same cycle as the next loss.
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 3);
            applyStimulus(1'b1, 1'b0, 11);
        end
        checkOutput("lost_cnt_five", int'(lost_cnt), 5);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 1);
        clr_stats = 1'b0;
        checkOutput("clr_with_loss_lost_cnt", int'(lost_cnt), 1);
        checkOutput("clr_with_loss_lock_lost", int'(lock_lost), 1);
        checkOutput("clr_with_loss_sys_rst_n", int'(sys_rst_n), 0);
        applyStimulus(1'b1, 1'b0, 11);
        checkOutput("relock_after_clr", int'(ready), 1);

        // No lock at all: periodic PLL reset pulses and saturating retry count.
        applyStimulus(1'b0, 1'b0, 3);
        n = 0;
        while (pll_rst == 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("first_timeout_pll_rst", int'(pll_rst), 1);
        checkOutput("first_timeout_retry", int'(retry_cnt), 1);
        hi = 0;
        while (pll_rst == 1'b1 && hi < 100) begin
            tick();
            hi++;
        end
        checkOutput("pll_rst_width", hi, P_RST);
        lo = 0;
        while (pll_rst == 1'b0 && lo < 100) begin
            tick();
            lo++;
        end
        checkOutput("pll_rst_gap", lo, P_TO);
        checkOutput("second_timeout_retry", int'(retry_cnt), 2);
        applyStimulus(1'b0, 1'b0, (P_RST + P_TO) * 15);
        checkOutput("retry_saturated", int'(retry_cnt), CNTMAX);
        checkOutput("no_lock_sys_rst_n", int'(sys_rst_n), 0);
        applyStimulus(1'b0, 1'b1, 1);
        clr_stats = 1'b0;
        checkOutput("lone_clr_lost_cnt", int'(lost_cnt), 0);
        checkOutput("lone_clr_retry_cnt", int'(retry_cnt), 0);
        checkOutput("lone_clr_lock_lost", int'(lock_lost), 0);

        // Random lock activity with occasional clears.
        repeat (150) begin
            lk   = 1'($urandom_range(0, 1));
            hold = lk ? $urandom_range(1, 30) : $urandom_range(1, 40);
            locked = lk;
            repeat (hold) begin
                clr_stats = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clr_stats = 1'b0;

        // Asynchronous reset mid-RUN takes effect between clock edges.
        applyStimulus(1'b1, 1'b0, 40);
        checkOutput("run_before_async_reset", int'(ready), 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_pll_rst", int'(pll_rst), 1);
        checkOutput("async_sys_rst_n", int'(sys_rst_n), 0);
        checkOutput("async_ready", int'(ready), 0);
        checkOutput("async_counters", int'({lock_lost, lost_cnt, retry_cnt}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, P_RST);
        checkOutput("restart_pll_rst_done", int'(pll_rst), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
